io_out_slew: RTL

IO_OUT_SLEW -- requirements
Module: io_out_slew

---
 rtl/io_out_slew.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/io_out_slew.sv
// Slew-controlled pad output driver: ramps thermometer-coded leg enables between high-Z and
// the requested drive strength. Define IO_OUT_SLEW_RAMP_EN for ramping; otherwise legs switch in one cycle.
module io_out_slew #(
  parameter int NUM_CH      = 4,
  parameter int NUM_LEGS    = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             data_i,
  input  logic                          oe_i,
  input  logic [$clog2(NUM_LEGS+1)-1:0] drive_max_i,
  output logic [NUM_CH-1:0]             pad_a_o,
  output logic [NUM_LEGS-1:0]           leg_oe_o,
  output logic                          driving_o,
  output logic                          busy_o
);

  localparam int            CW   = $clog2(NUM_LEGS + 1);
  localparam logic [CW-1:0] LEGS = CW'(NUM_LEGS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Bit 2 is the DRIVE flag and bit 1 the ramping flag, so both status outputs come straight off flops.
  typedef enum logic [2:0] {
    HIZ       = 3'b000,
    RAMP_UP   = 3'b010,
    RAMP_DOWN = 3'b011,
    DRIVE     = 3'b100
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tgt_new;

  // Requested strength clamped into 1..NUM_LEGS.
  always_comb begin
    // NOTE: default assignment first so every path assigns tgt_new and no latch is inferred.
    tgt_new = drive_max_i;
    if (drive_max_i > LEGS)
      tgt_new = LEGS;
    else if (drive_max_i == '0)
      tgt_new = ONE;
  end

  // Leg enables decode from cnt, so an asynchronous reset releases every leg at once.
  always_comb begin
    leg_oe_o = '0;
    for (int i = 0; i < NUM_LEGS; i++)
      leg_oe_o[i] = (i < int'(cnt));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pad_a_o <= '0;
    else
      pad_a_o <= data_i;
  end

  assign driving_o = state[2];

`ifdef IO_OUT_SLEW_RAMP_EN
  localparam int TW = $clog2(STEP_CYCLES + 1);

  logic [TW-1:0] timer;
  logic [CW-1:0] tgt;
  logic          step_hit;
  logic [CW-1:0] cnt_dn;
  logic [CW-1:0] cnt_toward;

  assign step_hit   = (timer == TW'(STEP_CYCLES - 1));
  assign cnt_dn     = cnt - ONE;
  assign cnt_toward = (cnt < tgt) ? cnt + ONE : cnt - ONE;
  assign busy_o     = state[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIZ;
      cnt   <= '0;
      timer <= '0;
      tgt   <= ONE;
    end else begin
      case (state)
        HIZ: begin
          if (oe_i) begin
            tgt   <= tgt_new;
            cnt   <= ONE;
            timer <= '0;
            state <= (tgt_new == ONE) ? DRIVE : RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!oe_i) begin
            // Release begins with one leg dropped on the abort edge itself.
            cnt   <= cnt_dn;
            timer <= '0;
            state <= (cnt_dn == '0) ? HIZ : RAMP_DOWN;
          end else if (cnt == tgt) begin
            timer <= '0;
            state <= DRIVE;
          end else if (step_hit) begin
            // Steps toward tgt from either side; a reversal may land above the new target.
            cnt   <= cnt_toward;
            timer <= '0;
            if (cnt_toward == tgt)
              state <= DRIVE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DRIVE: begin
          if (!oe_i) begin
            cnt   <= cnt_dn;
            timer <= '0;
            state <= (cnt_dn == '0) ? HIZ : RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (oe_i) begin
            tgt   <= tgt_new;
            timer <= '0;
            state <= RAMP_UP;
          end else if (step_hit) begin
            cnt   <= cnt_dn;
            timer <= '0;
            if (cnt_dn == '0)
              state <= HIZ;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= HIZ;
          cnt   <= '0;
          timer <= '0;
        end
      endcase
    end
  end

  cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= LEGS);
  timer_in_range: assert property (@(posedge clk) disable iff (!rst_n) timer <= TW'(STEP_CYCLES - 1));
`else
  assign busy_o = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIZ;
      cnt   <= '0;
    end else begin
      case (state)
        HIZ: begin
          if (oe_i) begin
            cnt   <= tgt_new;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          if (!oe_i) begin
            cnt   <= '0;
            state <= HIZ;
          end
        end
        default: begin
          cnt   <= '0;
          state <= HIZ;
        end
      endcase
    end
  end
`endif

endmodule
